// File: rtl/router_pkg.sv
// router_pkg: shared types and header helpers for router_nport.
// Field widths are passed in so the helpers serve any DATA_W/ADDR_W.
package router_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;
    localparam int LEN_W      = DEF_DATA_W - DEF_ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        HDR_WAIT,
        LOAD,
        CHECK,
        DROP
    } state_t;

    function automatic logic [31:0] hdr_addr(input logic [31:0] b,
                                             input int aw);
        return b & ((32'd1 << aw) - 32'd1);
    endfunction

    function automatic logic [31:0] hdr_len(input logic [31:0] b,
                                            input int aw);
        return b >> aw;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// router_fifo: first-word fall-through FIFO for one output port.
// An entry left unread for TIMEOUT cycles flushes the whole queue.
module router_fifo
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              full,
    output logic              flush
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     rp;
    logic [AW-1:0]     wp;
    logic [AW:0]       n;
    logic [TW-1:0]     tmo;
    logic              do_wr;
    logic              do_rd;

    assign valid = (n != '0);
    assign full  = (n == (AW+1)'(FIFO_DEPTH));
    assign do_wr = push && !full;
    assign do_rd = pop && valid;
    assign flush = valid && (tmo == TW'(TIMEOUT - 1));
    assign dout  = valid ? mem[rp] : '0;

    // Storage; a write landing on a flush edge becomes the new slot 0.
    always_ff @(posedge clock) begin
        if (do_wr)
            mem[flush ? '0 : wp] <= din;
    end

    // Pointers and occupancy; flush empties the queue except a same-cycle write.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rp <= '0;
            wp <= '0;
            n  <= '0;
        end else if (flush) begin
            rp <= '0;
            wp <= AW'(do_wr);
            n  <= (AW+1)'(do_wr);
        end else begin
            if (do_wr)
                wp <= wp + 1'b1;
            if (do_rd)
                rp <= rp + 1'b1;
            n <= n + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    // Unread-age counter; any pop or an empty queue restarts it.
    always_ff @(posedge clock) begin
        if (!resetn)
            tmo <= '0;
        else if (flush || !valid || do_rd)
            tmo <= '0;
        else
            tmo <= tmo + 1'b1;
    end

endmodule

// File: rtl/router_nport.sv
// router_nport: 1xN framed-packet router.
// Header steering, parity/length check and drop handling over N FIFOs.
module router_nport
    import router_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        pkt_valid,
    input  logic [DATA_W-1:0]           data_in,
    input  logic [NUM_PORTS-1:0]        read_enb,
    output logic                        busy,
    output logic                        error,
    output logic                        pkt_drop,
    output logic [NUM_PORTS-1:0]        valid_out,
    output logic [NUM_PORTS*DATA_W-1:0] data_out
);
    localparam int LW    = DATA_W - ADDR_W;
    localparam int NSLOT = 1 << ADDR_W;

    state_t st;
    state_t nxt;

    logic [ADDR_W-1:0]    addr_q;
    logic [ADDR_W-1:0]    h_addr;
    logic [ADDR_W-1:0]    wr_sel;
    logic [LW-1:0]        len_q;
    logic [LW-1:0]        h_len;
    logic [LW-1:0]        cnt_q;
    logic [DATA_W-1:0]    hdr_q;
    logic [DATA_W-1:0]    par_q;
    logic [DATA_W-1:0]    pb_q;
    logic [DATA_W-1:0]    wr_data;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] flush;
    logic [NUM_PORTS-1:0] wr_en;
    logic [NSLOT-1:0]     full_x;
    logic [NSLOT-1:0]     flush_x;
    logic                 hdr_ok;
    logic                 wr_go;
    logic                 drop_set;

    assign h_addr  = ADDR_W'(hdr_addr(32'(data_in), ADDR_W));
    assign h_len   = LW'(hdr_len(32'(data_in), ADDR_W));
    assign hdr_ok  = int'(h_addr) < NUM_PORTS;
    assign full_x  = NSLOT'(full);
    assign flush_x = NSLOT'(flush);

    // Packet FSM: next state, stall, FIFO write steering and drop pulse.
    always_comb begin
        nxt      = st;
        busy     = 1'b0;
        wr_go    = 1'b0;
        wr_sel   = addr_q;
        wr_data  = data_in;
        drop_set = 1'b0;
        unique case (st)
            IDLE: begin
                if (pkt_valid) begin
                    wr_sel = h_addr;
                    if (!hdr_ok)
                        nxt = DROP;
                    else if (full_x[h_addr])
                        nxt = HDR_WAIT;
                    else begin
                        wr_go = 1'b1;
                        nxt   = LOAD;
                    end
                end
            end
            HDR_WAIT: begin
                busy    = 1'b1;
                wr_data = hdr_q;
                if (flush_x[addr_q])
                    nxt = DROP;
                else if (!full_x[addr_q]) begin
                    wr_go = 1'b1;
                    nxt   = LOAD;
                end
            end
            LOAD: begin
                busy = full_x[addr_q];
                if (flush_x[addr_q]) begin
                    if (!busy && !pkt_valid) begin
                        drop_set = 1'b1;
                        nxt      = IDLE;
                    end else
                        nxt = DROP;
                end else if (!busy) begin
                    wr_go = 1'b1;
                    if (!pkt_valid)
                        nxt = CHECK;
                end
            end
            CHECK: begin
                busy = 1'b1;
                nxt  = IDLE;
            end
            DROP: begin
                if (!pkt_valid) begin
                    drop_set = 1'b1;
                    nxt      = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // One-hot write enable for the selected port.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++)
            wr_en[p] = wr_go && (wr_sel == ADDR_W'(p));
    end

    // State, header fields, running parity/length and status flags.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            st       <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            hdr_q    <= '0;
            par_q    <= '0;
            pb_q     <= '0;
            error    <= 1'b0;
            pkt_drop <= 1'b0;
        end else begin
            st       <= nxt;
            pkt_drop <= drop_set;
            if (st == IDLE && pkt_valid) begin
                addr_q <= h_addr;
                len_q  <= h_len;
                hdr_q  <= data_in;
                par_q  <= data_in;
                cnt_q  <= '0;
            end
            if (st == LOAD && !busy) begin
                if (pkt_valid) begin
                    par_q <= par_q ^ data_in;
                    if (cnt_q != '1)
                        cnt_q <= cnt_q + 1'b1;
                end else
                    pb_q <= data_in;
            end
            if (st == CHECK)
                error <= (par_q != pb_q) || (cnt_q != len_q);
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        router_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH),
            .TIMEOUT    (TIMEOUT)
        ) u_fifo (
            .clock (clock),
            .resetn(resetn),
            .push  (wr_en[p]),
            .din   (wr_data),
            .pop   (read_enb[p]),
            .dout  (data_out[p*DATA_W +: DATA_W]),
            .valid (valid_out[p]),
            .full  (full[p]),
            .flush (flush[p])
        );
    end

endmodule

// File: tb/tb_router_nport.sv
// tb_router_nport: directed bench for router_nport.
// Per-port scoreboard of written bytes, checked as each port pops.
module tb_router_nport;

    localparam int DATA_W     = 8;
    localparam int NUM_PORTS  = 3;
    localparam int ADDR_W     = 2;
    localparam int FIFO_DEPTH = 16;
    localparam int TIMEOUT    = 30;

    logic        clock     = 1'b0;
    logic        resetn    = 1'b0;
    logic        pkt_valid = 1'b0;
    logic [7:0]  data_in   = 8'h00;
    logic [2:0]  read_enb  = 3'b000;
    logic        busy;
    logic        error;
    logic        pkt_drop;
    logic [2:0]  valid_out;
    logic [23:0] data_out;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int cyc    = 0;
    int busy_n = 0;
    int drop_n = 0;
    logic last_busy = 1'b0;

    logic [7:0] sb [3][64];
    int hd [3];
    int tl [3];
    logic [7:0] pl [40];

    always #5 clock = ~clock;

    router_nport #(
        .DATA_W    (DATA_W),
        .NUM_PORTS (NUM_PORTS),
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .pkt_valid(pkt_valid),
        .data_in  (data_in),
        .read_enb (read_enb),
        .busy     (busy),
        .error    (error),
        .pkt_drop (pkt_drop),
        .valid_out(valid_out),
        .data_out (data_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        for (int p = 0; p < 3; p++) begin
            if (valid_out[p] === 1'b1 && read_enb[p] === 1'b1) begin
                if (hd[p] == tl[p])
                    chk($sformatf("port%0d_spurious", p),
                        32'(valid_out[p]), 32'd0);
                else begin
                    chk($sformatf("port%0d_data", p),
                        32'(data_out[p*8 +: 8]),
                        32'(sb[p][hd[p] % 64]));
                    hd[p]++;
                end
            end
        end
        if (busy === 1'b1) busy_n++;
        if (pkt_drop === 1'b1) drop_n++;
        last_busy = busy;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic send(input logic v, input logic [7:0] b, input int port);
        int k;
        pkt_valid = v;
        data_in   = b;
        for (k = 0; k < 200; k++) begin
            tick();
            if (last_busy === 1'b0) break;
        end
        if (k == 200)
            chk("send_stalled", 32'(busy), 32'd0);
        else if (port >= 0) begin
            sb[port][tl[port] % 64] = b;
            tl[port]++;
        end
    endtask

    task automatic close();
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        tick();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pkt(input logic [7:0] hdr, input int n, input int port,
                       input logic bad);
        logic [7:0] par;
        par = hdr;
        send(1'b1, hdr, port);
        for (int i = 0; i < n; i++) begin
            send(1'b1, pl[i], port);
            par ^= pl[i];
        end
        send(1'b0, bad ? par + 8'd1 : par, port);
        close();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b0;
        int d0;
        int h0;
        int t0;
        int t1;
        logic [7:0] par;

        resetn = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_drop", 32'(pkt_drop), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        resetn = 1'b1;
        tick();

        // good packet to port 1
        read_enb = 3'b010;
        for (int i = 0; i < 4; i++) pl[i] = 8'hA0 + 8'(i);
        b0 = busy_n;
        pkt(8'h11, 4, 1, 1'b0);
        drain(4);
        chk("t1_error", 32'(error), 32'd0);
        chk("t1_busy_cycles", 32'(busy_n - b0), 32'd1);
        chk("t1_bytes_out", 32'(hd[1]), 32'd6);

        // bad parity
        pkt(8'h11, 4, 1, 1'b1);
        drain(4);
        chk("t2_error", 32'(error), 32'd1);
        chk("t2_bytes_out", 32'(hd[1]), 32'd12);

        // invalid address drops
        pl[0] = 8'hB0;
        pl[1] = 8'hB1;
        b0 = busy_n;
        d0 = drop_n;
        pkt(8'h13, 2, -1, 1'b0);
        drain(2);
        chk("t3_drop_pulses", 32'(drop_n - d0), 32'd1);
        chk("t3_busy_cycles", 32'(busy_n - b0), 32'd0);
        chk("t3_valid", 32'(valid_out), 32'd0);
        chk("t3_error_held", 32'(error), 32'd1);

        // backpressure on a long packet to port 0
        read_enb = 3'b000;
        for (int i = 0; i < 32; i++) pl[i] = 8'hC0 + 8'(i);
        par = 8'h80;
        send(1'b1, 8'h80, 0);
        for (int i = 0; i < 15; i++) begin
            send(1'b1, pl[i], 0);
            par ^= pl[i];
        end
        chk("t4_busy_full", 32'(busy), 32'd1);
        chk("t4_valid0", 32'(valid_out[0]), 32'd1);
        read_enb = 3'b001;
        for (int i = 15; i < 32; i++) begin
            send(1'b1, pl[i], 0);
            par ^= pl[i];
        end
        send(1'b0, par, 0);
        close();
        drain(24);
        chk("t4_error", 32'(error), 32'd0);
        chk("t4_bytes_out", 32'(hd[0]), 32'd34);
        chk("t4_valid0_empty", 32'(valid_out[0]), 32'd0);

        // length mismatch
        read_enb = 3'b010;
        for (int i = 0; i < 3; i++) pl[i] = 8'hD0 + 8'(i);
        pkt(8'h15, 3, 1, 1'b0);
        drain(4);
        chk("t5_len_error", 32'(error), 32'd1);
        chk("t5_drained", 32'(hd[1]), 32'(tl[1]));

        // unread port 2 times out
        read_enb = 3'b000;
        send(1'b1, 8'h0A, 2);
        t0 = cyc;
        chk("t6_hdr_valid", 32'(valid_out[2]), 32'd1);
        chk("t6_hdr_data", 32'(data_out[23:16]), 32'h0A);
        pl[0] = 8'hE0;
        pl[1] = 8'hE1;
        par = 8'h0A ^ 8'hE0 ^ 8'hE1;
        send(1'b1, pl[0], 2);
        send(1'b1, pl[1], 2);
        send(1'b0, par, 2);
        close();
        for (int k = 0; k < 60 && valid_out[2] === 1'b1; k++) tick();
        t1 = cyc;
        chk("t6_timeout_cycles", 32'(t1 - t0), 32'd30);
        chk("t6_valid2", 32'(valid_out[2]), 32'd0);
        chk("t6_error", 32'(error), 32'd0);
        hd[2] = tl[2];

        read_enb = 3'b100;
        h0 = hd[2];
        pkt(8'h0A, 2, 2, 1'b0);
        drain(4);
        chk("t6_after_bytes", 32'(hd[2] - h0), 32'd4);
        chk("t6_after_error", 32'(error), 32'd0);

        // reset in the middle of a packet
        read_enb = 3'b000;
        send(1'b1, 8'h04, 0);
        send(1'b1, 8'h55, 0);
        resetn    = 1'b0;
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        tick();
        resetn = 1'b1;
        chk("t7_rst_valid", 32'(valid_out), 32'd0);
        chk("t7_rst_busy", 32'(busy), 32'd0);
        for (int p = 0; p < 3; p++) hd[p] = tl[p];
        read_enb = 3'b001;
        h0 = hd[0];
        pl[0] = 8'h77;
        pkt(8'h04, 1, 0, 1'b0);
        drain(4);
        chk("t7_after_bytes", 32'(hd[0] - h0), 32'd3);
        chk("t7_after_error", 32'(error), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
